frontend_request_arbiter: RTL and testbench

Multi-requester front end for the DDR3 backend controller. Arbitrates round-robin among NUM_REQ requesters and buffers accepted commands and write data in order. Presents a show-ahead command stream and write-data stream to the backend. Routes returned read data to the originating requester using an in-order tag FIFO, and back-pressures the backend return path through its stall input.

---
 rtl/frontend_request_arbiter.sv | 134 +++++++++++++
 tb/tb_frontend_request_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_request_arbiter.sv
// frontend_request_arbiter: round-robin front end feeding the DDR3 backend, with in-order read-return routing
`ifndef FRONTEND_CMD_BITS
`define FRONTEND_CMD_BITS 32
`endif
`ifndef DQ_BITS
`define DQ_BITS 8
`endif

module frontend_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CMD_W = `FRONTEND_CMD_BITS,
    parameter int DATA_W = `DQ_BITS*8,
    parameter int CMD_DEPTH = 4,
    parameter int TAG_DEPTH = 8,
    parameter int OP_LSB = 0,
    parameter int OP_W = 2,
    parameter logic [OP_W-1:0] OP_READ = 1
) (
    input  logic                      clk,
    input  logic                      power_on_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*CMD_W-1:0]  i_req_command,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_write_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rdata_valid,
    output logic [DATA_W-1:0]         o_rdata,
    input  logic [NUM_REQ-1:0]        i_rdata_ready,
    output logic                      o_frontend_command_valid,
    output logic [CMD_W-1:0]          o_frontend_command,
    input  logic                      i_backend_controller_ready,
    output logic [DATA_W-1:0]         o_frontend_write_data,
    input  logic                      i_backend_controller_ren,
    input  logic [DATA_W-1:0]         i_backend_read_data,
    input  logic                      i_backend_read_data_valid,
    output logic                      o_backend_controller_stall,
    output logic                      o_err_wdata_underflow,
    output logic                      o_err_tag_underflow
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CA = $clog2(CMD_DEPTH);
    localparam int TA = $clog2(TAG_DEPTH);

    logic [NUM_REQ-1:0]   is_rd, elig;
    logic [2*NUM_REQ-1:0] rot;
    logic [IW-1:0]        rr, off, gnt, h;
    logic [IW:0]          sum;
    logic                 found, acc_rd;
    logic [CMD_W-1:0]     cmd_mem [CMD_DEPTH];
    logic [DATA_W-1:0]    wd_mem [CMD_DEPTH];
    logic [IW-1:0]        tag_mem [TAG_DEPTH];
    logic [CA-1:0]        cmd_wr, cmd_rd, wd_wr, wd_rd;
    logic [TA-1:0]        tag_wr, tag_rd;
    logic [CA:0]          cmd_cnt, wd_cnt;
    logic [TA:0]          tag_cnt;
    logic                 cmd_full, wd_full, tag_full, wd_ne, tag_ne;
    logic                 cmd_push, wd_push, tag_push, cmd_pop, wd_pop, tag_pop;

    assign cmd_full = cmd_cnt == (CA+1)'(CMD_DEPTH);
    assign wd_full  = wd_cnt == (CA+1)'(CMD_DEPTH);
    assign tag_full = tag_cnt == (TA+1)'(TAG_DEPTH);
    assign wd_ne    = wd_cnt != '0;
    assign tag_ne   = tag_cnt != '0;

    // Eligibility per requester, then first eligible at or after rr via a doubled rotate
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            is_rd[k] = i_req_command[k*CMD_W+OP_LSB +: OP_W] == OP_READ;
            elig[k]  = i_req_valid[k] & ~power_on_rst & ~cmd_full & (is_rd[k] ? ~tag_full : ~wd_full);
        end
        rot = {elig, elig} >> rr;
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        found = |elig;
        sum = {1'b0, rr} + {1'b0, off};
        gnt = IW'(sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum);
    end

    assign o_req_ready = found ? NUM_REQ'(1) << gnt : '0;
    assign acc_rd      = is_rd[gnt];
    assign cmd_push    = found;
    assign wd_push     = found & ~acc_rd;
    assign tag_push    = found & acc_rd;

    assign o_frontend_command_valid = cmd_cnt != '0;
    assign o_frontend_command       = o_frontend_command_valid ? cmd_mem[cmd_rd] : '0;
    assign o_frontend_write_data    = wd_ne ? wd_mem[wd_rd] : '0;
    assign cmd_pop = o_frontend_command_valid & i_backend_controller_ready;
    assign wd_pop  = i_backend_controller_ren & wd_ne;

    assign h                          = tag_mem[tag_rd];
    assign tag_pop                    = tag_ne & i_backend_read_data_valid & i_rdata_ready[h];
    assign o_rdata_valid              = (tag_ne & i_backend_read_data_valid) ? NUM_REQ'(1) << h : '0;
    assign o_rdata                    = tag_ne ? i_backend_read_data : '0;
    assign o_backend_controller_stall = tag_ne & i_backend_read_data_valid & ~i_rdata_ready[h];

    // FIFO pointers and counts, round-robin pointer and sticky error flags
    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            cmd_wr <= '0;
            cmd_rd <= '0;
            cmd_cnt <= '0;
            wd_wr <= '0;
            wd_rd <= '0;
            wd_cnt <= '0;
            tag_wr <= '0;
            tag_rd <= '0;
            tag_cnt <= '0;
            rr <= '0;
            o_err_wdata_underflow <= 1'b0;
            o_err_tag_underflow <= 1'b0;
        end else begin
            cmd_wr <= cmd_wr + CA'(cmd_push);
            cmd_rd <= cmd_rd + CA'(cmd_pop);
            cmd_cnt <= cmd_cnt + (CA+1)'(cmd_push) - (CA+1)'(cmd_pop);
            wd_wr <= wd_wr + CA'(wd_push);
            wd_rd <= wd_rd + CA'(wd_pop);
            wd_cnt <= wd_cnt + (CA+1)'(wd_push) - (CA+1)'(wd_pop);
            tag_wr <= tag_wr + TA'(tag_push);
            tag_rd <= tag_rd + TA'(tag_pop);
            tag_cnt <= tag_cnt + (TA+1)'(tag_push) - (TA+1)'(tag_pop);
            rr <= found ? (gnt == IW'(NUM_REQ - 1) ? '0 : gnt + IW'(1)) : rr;
            o_err_wdata_underflow <= o_err_wdata_underflow | (i_backend_controller_ren & ~wd_ne);
            o_err_tag_underflow <= o_err_tag_underflow | (i_backend_read_data_valid & ~tag_ne);
        end
    end

    // Queue storage; contents are don't-care until the matching count says valid
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr] <= i_req_command[gnt*CMD_W +: CMD_W];
        if (wd_push) wd_mem[wd_wr] <= i_req_write_data[gnt*DATA_W +: DATA_W];
        if (tag_push) tag_mem[tag_wr] <= gnt;
    end
endmodule

// File: tb/tb_frontend_request_arbiter.sv
// tb_frontend_request_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_frontend_request_arbiter;
    logic         clk = 0;
    logic         rst = 0;
    logic [3:0]   req_valid;
    logic [127:0] req_cmd;
    logic [255:0] req_wd;
    logic [3:0]   req_ready, rdata_valid, rdata_ready;
    logic [63:0]  rdata, wdata, rd_data;
    logic         cmd_valid, bc_ready, ren, rd_valid, stall, err_wd, err_tag;
    logic [31:0]  cmd;
    int           n_cmp = 0;
    int           n_bad = 0;

    logic [31:0]  m_cmd[$];
    logic [63:0]  m_wd[$];
    int           m_tag[$];
    int           m_rr = 0;
    bit           m_ewd = 0;
    bit           m_etag = 0;

    frontend_request_arbiter #(.NUM_REQ(4), .CMD_W(32), .DATA_W(64), .CMD_DEPTH(4), .TAG_DEPTH(8)) dut (
        .clk(clk), .power_on_rst(rst), .i_req_valid(req_valid), .i_req_command(req_cmd),
        .i_req_write_data(req_wd), .o_req_ready(req_ready), .o_rdata_valid(rdata_valid),
        .o_rdata(rdata), .i_rdata_ready(rdata_ready), .o_frontend_command_valid(cmd_valid),
        .o_frontend_command(cmd), .i_backend_controller_ready(bc_ready),
        .o_frontend_write_data(wdata), .i_backend_controller_ren(ren),
        .i_backend_read_data(rd_data), .i_backend_read_data_valid(rd_valid),
        .o_backend_controller_stall(stall), .o_err_wdata_underflow(err_wd),
        .o_err_tag_underflow(err_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(int k, int n, bit rd);
        return {8'(k), 8'(n), 14'h2A5, rd ? 2'b01 : 2'b00};
    endfunction

    function automatic logic [63:0] mkd(int k, int n);
        return {32'hD0A7_0000 | 32'(k), 32'(n) ^ 32'h5A5A_5A5A};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_req(int k, bit v, bit rd, int n);
        req_valid[k] = v;
        req_cmd[k*32 +: 32] = mk(k, n, rd);
        req_wd[k*64 +: 64] = mkd(k, n);
    endtask

    function automatic int exp_grant();
        if (rst || m_cmd.size() >= 4) return -1;
        for (int i = 0; i < 4; i++) begin
            int k;
            logic [31:0] c;
            k = (m_rr + i) % 4;
            c = req_cmd[k*32 +: 32];
            if (req_valid[k] && ((c[1:0] == 2'b01) ? m_tag.size() < 8 : m_wd.size() < 4)) return k;
        end
        return -1;
    endfunction

    initial forever begin
        int g;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cmd.delete();
            m_wd.delete();
            m_tag.delete();
            m_rr = 0;
            m_ewd = 0;
            m_etag = 0;
        end else begin
            g = exp_grant();
            if (m_cmd.size() > 0 && bc_ready) void'(m_cmd.pop_front());
            if (ren) begin
                if (m_wd.size() > 0) void'(m_wd.pop_front());
                else m_ewd = 1;
            end
            if (rd_valid) begin
                if (m_tag.size() == 0) m_etag = 1;
                else if (rdata_ready[m_tag[0]]) void'(m_tag.pop_front());
            end
            if (g >= 0) begin
                m_cmd.push_back(req_cmd[g*32 +: 32]);
                if (req_cmd[g*32 +: 2] == 2'b01) m_tag.push_back(g);
                else m_wd.push_back(req_wd[g*64 +: 64]);
                m_rr = (g + 1) % 4;
            end
        end
    end

    initial forever begin
        int g;
        logic [3:0] e_rv;
        logic e_st;
        @(negedge clk);
        g = exp_grant();
        e_rv = 0;
        e_st = 0;
        if (m_tag.size() > 0 && rd_valid) begin
            e_rv = 4'(1 << m_tag[0]);
            e_st = !rdata_ready[m_tag[0]];
        end
        check("m_ready", req_ready, g >= 0 ? 64'(1) << g : 64'd0);
        check("m_cmd_valid", cmd_valid, m_cmd.size() > 0);
        check("m_cmd", cmd, m_cmd.size() > 0 ? m_cmd[0] : 0);
        check("m_wdata", wdata, m_wd.size() > 0 ? m_wd[0] : 0);
        check("m_rdata_valid", rdata_valid, e_rv);
        check("m_rdata", rdata, m_tag.size() > 0 ? rd_data : 0);
        check("m_stall", stall, e_st);
        check("m_err_wd", err_wd, m_ewd);
        check("m_err_tag", err_tag, m_etag);
    end

    initial begin
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        req_valid = 0;
        req_cmd = 0;
        req_wd = 0;
        rdata_ready = 0;
        bc_ready = 0;
        ren = 0;
        rd_valid = 0;
        rd_data = 0;
        #1 rst = 1;
        for (int k = 0; k < 4; k++) set_req(k, 1, 0, k);
        repeat (3) begin
            @(posedge clk); #3;
            check("rst_ready", req_ready, 0);
            check("rst_cmd_valid", cmd_valid, 0);
            check("rst_errs", {err_wd, err_tag}, 0);
        end
        @(posedge clk); #1;
        req_valid = 0;
        rst = 0;
        #2;
        check("rel_ready", req_ready, 0);
        check("rel_cmd_valid", cmd_valid, 0);
        check("rel_errs", {err_wd, err_tag}, 0);

        bc_ready = 1;
        for (int t = 0; t < 6; t++) begin
            @(posedge clk); #1;
            if (t == 0) for (int k = 0; k < 4; k++) set_req(k, 1, 0, 10 + k);
            ren = t > 0;
            #2;
            check("rr_grant", req_ready, 64'(1) << seq[t]);
            if (t > 0) begin
                check("rr_cmd", cmd, mk(seq[t-1], 10 + seq[t-1], 0));
                check("rr_wdata", wdata, mkd(seq[t-1], 10 + seq[t-1]));
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
        #2;
        check("rr_last_cmd", cmd, mk(1, 11, 0));
        @(posedge clk); #1;
        ren = 0;
        bc_ready = 0;

        for (int t = 0; t < 7; t++) begin
            @(posedge clk); #1;
            set_req(1, 1, 0, 20 + t);
            bc_ready = t == 5;
            ren = t == 5;
            #2;
            check("bp_ready", req_ready, (t == 4 || t == 5) ? 0 : 4'b0010);
            if (t == 5) check("bp_head", cmd, mk(1, 20, 0));
        end
        @(posedge clk); #1;
        req_valid = 0;
        bc_ready = 1;
        ren = 1;
        repeat (4) @(posedge clk);
        #1;
        bc_ready = 0;
        ren = 0;

        @(posedge clk); #1;
        bc_ready = 1;
        set_req(2, 1, 1, 30);
        #2 check("rd_grant2", req_ready, 4'b0100);
        @(posedge clk); #1;
        set_req(2, 0, 1, 30);
        set_req(0, 1, 1, 31);
        #2 check("rd_grant0", req_ready, 4'b0001);
        @(posedge clk); #1;
        set_req(0, 0, 1, 31);
        rdata_ready = 4'hF;
        rd_valid = 1;
        rd_data = 64'hA;
        #2;
        check("rd_valid_a", rdata_valid, 4'b0100);
        check("rd_data_a", rdata, 64'hA);
        @(posedge clk); #1;
        rd_data = 64'hB;
        #2;
        check("rd_valid_b", rdata_valid, 4'b0001);
        check("rd_data_b", rdata, 64'hB);
        @(posedge clk); #1;
        rd_valid = 0;

        set_req(2, 1, 1, 40);
        @(posedge clk); #1;
        set_req(2, 0, 1, 40);
        rdata_ready = 4'b1011;
        rd_valid = 1;
        rd_data = 64'hC;
        for (int t = 0; t < 3; t++) begin
            #2;
            check("st_stall", stall, 1);
            check("st_held", rdata_valid, 4'b0100);
            @(posedge clk); #1;
        end
        rdata_ready = 4'hF;
        #2;
        check("st_release", stall, 0);
        check("st_deliver", rdata_valid, 4'b0100);
        @(posedge clk); #1;
        rd_data = 64'hD;
        #2;
        check("tu_rvalid", rdata_valid, 0);
        check("tu_stall", stall, 0);
        check("tu_err_before", err_tag, 0);
        @(posedge clk); #1;
        rd_valid = 0;
        #2 check("tu_err_after", err_tag, 1);

        @(posedge clk); #1;
        ren = 1;
        #2 check("wu_err_before", err_wd, 0);
        @(posedge clk); #1;
        ren = 0;
        #2 check("wu_err_after", err_wd, 1);

        bc_ready = 0;
        @(posedge clk); #1;
        set_req(3, 1, 0, 50);
        @(posedge clk); #1;
        set_req(3, 0, 0, 50);
        #1 check("ar_before", cmd_valid, 1);
        rst = 1;
        #1;
        check("ar_cmd_valid", cmd_valid, 0);
        check("ar_errs", {err_wd, err_tag}, 0);
        @(posedge clk); #1;
        rst = 0;
        #2;
        check("ar_after_cmd_valid", cmd_valid, 0);
        check("ar_after_wdata", wdata, 0);
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
